memory_pipe: RTL and testbench

Parametrised single-port synchronous memory for simulation and FPGA benches, generalising the fixed 32-bit byte-masked memory: configurable word count, word width in bytes and read latency, plus a valid/ready request handshake and a read-data valid strobe. It sits between the pipeline's data/instruction bus and the bench or SoC top. Contents are preloaded from a hex file, and optional pseudo-random wait states exercise the core's stall paths.

---
 rtl/memory_pipe.sv | 143 ++++++++++++++
 tb/tb_memory_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_pipe.sv
// memory_pipe -- parametrised single-port synchronous memory with a
// valid/ready request handshake and a fixed-latency read pipeline.
//
// Optional feature macro: MEMORY_STALL_EN
//   defined     : an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5)
//                 drives ready, inserting pseudo-random wait states.
//   not defined : ready is 1 in every cycle after reset.
//
// Parameters
//   WIDTH   : address bits, depth = 2**WIDTH words
//   BYTES   : bytes per word (4 or 8), data width = 8*BYTES
//   LATENCY : read latency in cycles from accept to rvalid (1..4)
//   CONTENT : preload file name ("" = no preload)
//
// Ports
//   clk    in   clock, all logic on posedge
//   rstn   in   synchronous active-low reset
//   valid  in   request present
//   write  in   1 = write, 0 = read
//   wmask  in   byte enables for writes (bit i -> wdata[8i+7:8i])
//   wdata  in   write data
//   addr   in   word address
//   ready  out  request accepted this cycle when valid is high
//   rdata  out  read data, holds last completed read
//   rvalid out  one-cycle strobe per completed read
module memory_pipe #(
  parameter int    WIDTH   = 13,
  parameter int    BYTES   = 4,
  parameter int    LATENCY = 1,
  parameter string CONTENT = ""
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 valid,
  input  logic                 write,
  input  logic [BYTES-1:0]     wmask,
  input  logic [8*BYTES-1:0]   wdata,
  input  logic [WIDTH-1:0]     addr,
  output logic                 ready,
  output logic [8*BYTES-1:0]   rdata,
  output logic                 rvalid
);

  localparam int DW    = 8 * BYTES;
  localparam int DEPTH = 1 << WIDTH;

  logic [DW-1:0]      mem_q [DEPTH];
  logic               ready_q;
  logic               ready_d;
  logic [LATENCY-1:0] pv_q;
  logic [LATENCY-1:0] pv_d;
  logic [DW-1:0]      pd_q [LATENCY];
  logic [DW-1:0]      pd_d [LATENCY];
  logic               accept;
  logic               rd_accept;
  logic               wr_accept;

  // rstn is part of the accept term so nothing is accepted while in reset.
  assign accept    = valid & ready_q & rstn;
  assign rd_accept = accept & ~write;
  assign wr_accept = accept & write;

`ifdef MEMORY_STALL_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // LFSR advance and wait-state decision (ready low when lfsr[1:0] == 0).
  always_comb begin
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    ready_d = (lfsr_q[1:0] != 2'b00);
  end

  // LFSR state register, reseeded on every reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign ready_d = 1'b1;
`endif

  // Registered ready: rises the cycle after the first edge that sees rstn=1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  // Byte-masked write; runs in the same edge as the read sample of other
  // requests, but a single port means read and write never share an edge.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (wr_accept && wmask[b]) begin
        mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read pipeline next state: stage 0 samples the array, later stages shift.
  // A stage's data only moves when its incoming valid is set, so the last
  // stage holds the most recent completed read while rvalid is low.
  always_comb begin
    pv_d     = '0;
    pd_d     = pd_q;
    pv_d[0]  = rd_accept;
    if (rd_accept) begin
      pd_d[0] = mem_q[addr];
    end else begin
      pd_d[0] = pd_q[0];
    end
    for (int i = 1; i < LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      if (pv_q[i-1]) begin
        pd_d[i] = pd_q[i-1];
      end else begin
        pd_d[i] = pd_q[i];
      end
    end
  end

  // Read pipeline registers; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pv_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q <= pv_d;
      pd_q <= pd_d;
    end
  end

  assign ready  = ready_q;
  assign rvalid = pv_q[LATENCY-1];
  assign rdata  = pd_q[LATENCY-1];

endmodule

// File: tb/tb_memory_pipe.sv
// Self-checking bench for memory_pipe. Four instances share one stimulus
// stream: LATENCY 1/3/4 with 32-bit words and LATENCY 1 with 64-bit words.
// Expected outputs come from a history-based reference model.
module tb_memory_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic        write;
  logic [7:0]  wmask;
  logic [63:0] wdata;
  logic [3:0]  addr;

  logic        ready1, ready3, ready4, ready8;
  logic        rv1, rv3, rv4, rv8;
  logic [31:0] rd1, rd3, rd4;
  logic [63:0] rd8;

  always #5 clk = ~clk;

  memory_pipe #(.WIDTH(4), .BYTES(4), .LATENCY(1)) u_l1 (
    .clk(clk), .rstn(rstn), .valid(valid), .write(write), .wmask(wmask[3:0]),
    .wdata(wdata[31:0]), .addr(addr), .ready(ready1), .rdata(rd1), .rvalid(rv1));
  memory_pipe #(.WIDTH(4), .BYTES(4), .LATENCY(3)) u_l3 (
    .clk(clk), .rstn(rstn), .valid(valid), .write(write), .wmask(wmask[3:0]),
    .wdata(wdata[31:0]), .addr(addr), .ready(ready3), .rdata(rd3), .rvalid(rv3));
  memory_pipe #(.WIDTH(4), .BYTES(4), .LATENCY(4)) u_l4 (
    .clk(clk), .rstn(rstn), .valid(valid), .write(write), .wmask(wmask[3:0]),
    .wdata(wdata[31:0]), .addr(addr), .ready(ready4), .rdata(rd4), .rvalid(rv4));
  memory_pipe #(.WIDTH(4), .BYTES(8), .LATENCY(1)) u_b8 (
    .clk(clk), .rstn(rstn), .valid(valid), .write(write), .wmask(wmask),
    .wdata(wdata), .addr(addr), .ready(ready8), .rdata(rd8), .rvalid(rv8));

  logic        dut_ready [4];
  logic        dut_rv    [4];
  logic [63:0] dut_rd    [4];
  assign dut_ready[0] = ready1;  assign dut_rv[0] = rv1;  assign dut_rd[0] = {32'h0, rd1};
  assign dut_ready[1] = ready3;  assign dut_rv[1] = rv3;  assign dut_rd[1] = {32'h0, rd3};
  assign dut_ready[2] = ready4;  assign dut_rv[2] = rv4;  assign dut_rd[2] = {32'h0, rd4};
  assign dut_ready[3] = ready8;  assign dut_rv[3] = rv8;  assign dut_rd[3] = rd8;

  // Reference model state
  logic [31:0] m32 [16];
  logic [63:0] m64 [16];
  bit          hist_v [4096];
  logic [31:0] hd32   [4096];
  logic [63:0] hd64   [4096];
  int          cyc = 0;
  int          last_rst = 0;
  bit          exp_ready = 1'b0;
  logic [7:0]  lfsr = 8'hA5;
  bit          last_acc;
  bit          exp_rv [4];
  logic [63:0] exp_rd [4];
  logic [31:0] q3 [$];
  int          q3c [$];

  int checks = 0;
  int passed = 0;

  // One clock: update the model with what the inputs request, then advance.
  task automatic step();
    bit acc;
    int idx;
    int lat;
    acc      = valid && exp_ready && rstn;
    last_acc = acc;
    cyc++;
    hist_v[cyc] = acc && !write;
    hd32[cyc]   = m32[addr];
    hd64[cyc]   = m64[addr];
    if (acc && write) begin
      for (int b = 0; b < 8; b++) if (wmask[b]) m64[addr][8*b +: 8] = wdata[8*b +: 8];
      for (int b = 0; b < 4; b++) if (wmask[b]) m32[addr][8*b +: 8] = wdata[8*b +: 8];
    end
    if (!rstn) begin
      last_rst  = cyc;
      exp_ready = 1'b0;
      lfsr      = 8'hA5;
    end else begin
`ifdef MEMORY_STALL_EN
      exp_ready = (lfsr % 8'd4) != 8'd0;
`else
      exp_ready = 1'b1;
`endif
      lfsr = {lfsr[6:0], ^(lfsr & 8'hB8)};
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      lat = (k == 1) ? 3 : ((k == 2) ? 4 : 1);
      idx = cyc - lat + 1;
      exp_rv[k] = (idx >= 1) && hist_v[idx] && (last_rst < idx);
      if (!rstn) exp_rd[k] = 64'h0;
      else if (exp_rv[k]) exp_rd[k] = (k == 3) ? hd64[idx] : {32'h0, hd32[idx]};
    end
    if (rv3) begin
      q3.push_back(rd3);
      q3c.push_back(cyc);
    end
  endtask

  // Present one request and hold it until the model says it was accepted.
  task automatic issue(input bit w, input logic [3:0] a, input logic [63:0] d,
                       input logic [7:0] m, output int acc_cyc);
    int n;
    n = 0;
    valid = 1'b1; write = w; addr = a; wdata = d; wmask = m;
    do begin
      step();
      n++;
    end while (!last_acc && n < 64);
    if (!last_acc) begin
      checks++;
      $display("FAIL issue_timeout got no accept required accept within 64 cycles");
    end
    acc_cyc = cyc;
    valid = 1'b0;
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rstn = 1'b0; valid = 1'b0; write = 1'b0; wmask = 8'h0; wdata = 64'h0; addr = 4'h0;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (dut_ready[k] !== 1'b0) $display("FAIL reset_ready[%0d] got %b want 0", k, dut_ready[k]); else passed++;
      checks++; if (dut_rv[k] !== 1'b0) $display("FAIL reset_rvalid[%0d] got %b want 0", k, dut_rv[k]); else passed++;
      checks++; if (dut_rd[k] !== 64'h0) $display("FAIL reset_rdata[%0d] got %h want 0", k, dut_rd[k]); else passed++;
    end
    rstn = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (dut_ready[k] !== 1'b1) $display("FAIL ready_rise[%0d] got %b want 1", k, dut_ready[k]); else passed++;
    end
  endtask

  task automatic test_fill();
    int c;
    for (int a = 0; a < 16; a++) begin
      issue(1'b1, a[3:0], {$urandom, $urandom}, 8'hFF, c);
      for (int k = 0; k < 4; k++) begin
        checks++; if (dut_rv[k] !== 1'b0) $display("FAIL write_rvalid[%0d] got %b want 0", k, dut_rv[k]); else passed++;
      end
    end
  endtask

  task automatic test_byte_mask();
    int c;
    issue(1'b1, 4'd5, 64'h0000_0000_AABB_CCDD, 8'hFF, c);
    issue(1'b1, 4'd5, 64'h0000_0000_1122_3344, 8'h05, c);
    issue(1'b0, 4'd5, 64'h0, 8'h00, c);
    checks++; if (rv1 !== 1'b1) $display("FAIL mask_rvalid got %b want 1", rv1); else passed++;
    checks++; if (rd1 !== 32'hAA22CC44) $display("FAIL mask_rdata got %h want aa22cc44", rd1); else passed++;
    issue(1'b1, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, c);
    issue(1'b0, 4'd5, 64'h0, 8'h00, c);
    checks++; if (rd1 !== 32'hAA22CC44) $display("FAIL mask_zero got %h want aa22cc44", rd1); else passed++;
    idle(5);
  endtask

  task automatic test_bytes8();
    int c;
    issue(1'b1, 4'd7, 64'hFEDC_BA98_7654_3210, 8'hFF, c);
    issue(1'b1, 4'd7, 64'h0123_4567_89AB_CDEF, 8'hF0, c);
    issue(1'b0, 4'd7, 64'h0, 8'h00, c);
    checks++; if (rv8 !== 1'b1) $display("FAIL b8_rvalid got %b want 1", rv8); else passed++;
    checks++; if (rd8 !== 64'h0123_4567_7654_3210) $display("FAIL b8_rdata got %h want 0123456776543210", rd8); else passed++;
    idle(5);
  endtask

  task automatic test_latency();
    logic [31:0] pre [4];
    int c0;
    int c;
    for (int i = 0; i < 4; i++) pre[i] = m32[i];
    q3.delete();
    q3c.delete();
    issue(1'b0, 4'd0, 64'h0, 8'h00, c0);
    for (int i = 1; i < 4; i++) issue(1'b0, i[3:0], 64'h0, 8'h00, c);
    issue(1'b1, 4'd0, {$urandom, $urandom}, 8'hFF, c);
    for (int t = 0; t < 6; t++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        checks++; if (dut_rv[k] !== exp_rv[k]) $display("FAIL lat_rvalid[%0d] got %b want %b", k, dut_rv[k], exp_rv[k]); else passed++;
        checks++; if (dut_rd[k] !== exp_rd[k]) $display("FAIL lat_rdata[%0d] got %h want %h", k, dut_rd[k], exp_rd[k]); else passed++;
      end
    end
    checks++; if (q3.size() !== 4) $display("FAIL lat3_pulses got %0d want 4", q3.size()); else passed++;
    if (q3.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (q3[i] !== pre[i]) $display("FAIL lat3_data[%0d] got %h want %h", i, q3[i], pre[i]); else passed++;
      end
      checks++; if (q3c[0] !== c0 + 2) $display("FAIL lat3_first got cycle %0d want %0d", q3c[0], c0 + 2); else passed++;
`ifndef MEMORY_STALL_EN
      checks++; if (q3c[3] - q3c[0] !== 3) $display("FAIL lat3_consecutive got span %0d want 3", q3c[3] - q3c[0]); else passed++;
`endif
    end
  endtask

  task automatic test_reset_mid();
    int c;
    issue(1'b0, 4'd2, 64'h0, 8'h00, c);
    step();
    rstn = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (dut_ready[k] !== 1'b0) $display("FAIL midrst_ready[%0d] got %b want 0", k, dut_ready[k]); else passed++;
    end
    rstn = 1'b1;
    for (int t = 0; t < 6; t++) begin
      step();
      checks++; if (rv4 !== 1'b0) $display("FAIL midrst_rvalid got %b want 0", rv4); else passed++;
      checks++; if (rd4 !== 32'h0) $display("FAIL midrst_rdata got %h want 0", rd4); else passed++;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      rstn  = ($urandom_range(0, 39) != 0);
      valid = $urandom_range(0, 3) != 0;
      write = $urandom_range(0, 2) == 0;
      addr  = 4'($urandom);
      wdata = {$urandom, $urandom};
      wmask = 8'($urandom);
      step();
      for (int k = 0; k < 4; k++) begin
        checks++; if (dut_ready[k] !== exp_ready) $display("FAIL rnd_ready[%0d] got %b want %b cyc %0d", k, dut_ready[k], exp_ready, cyc); else passed++;
        checks++; if (dut_rv[k] !== exp_rv[k]) $display("FAIL rnd_rvalid[%0d] got %b want %b cyc %0d", k, dut_rv[k], exp_rv[k], cyc); else passed++;
        checks++; if (dut_rd[k] !== exp_rd[k]) $display("FAIL rnd_rdata[%0d] got %h want %h cyc %0d", k, dut_rd[k], exp_rd[k], cyc); else passed++;
      end
    end
    rstn = 1'b1;
    idle(5);
  endtask

`ifdef MEMORY_STALL_EN
  task automatic test_stall();
    int n;
    int pulses;
    int t;
    n = 0; pulses = 0; t = 0;
    write = 1'b0;
    while ((n < 100 || pulses < 100) && t < 800) begin
      valid = (n < 100);
      addr  = n[3:0];
      step();
      t++;
      checks++; if (ready1 !== exp_ready) $display("FAIL stall_ready got %b want %b cyc %0d", ready1, exp_ready, cyc); else passed++;
      if (last_acc) n++;
      if (rv1) begin
        checks++; if (rd1 !== m32[pulses % 16]) $display("FAIL stall_order[%0d] got %h want %h", pulses, rd1, m32[pulses % 16]); else passed++;
        pulses++;
      end
    end
    valid = 1'b0;
    idle(3);
    checks++; if (pulses !== 100) $display("FAIL stall_pulses got %0d want 100", pulses); else passed++;
    checks++; if (n !== 100) $display("FAIL stall_accepts got %0d want 100", n); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_byte_mask();
    test_bytes8();
    test_latency();
    test_reset_mid();
    test_random();
`ifdef MEMORY_STALL_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
